// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-addressable data memory with sized loads/stores.
// Registers load data and pass-through controls into the MEM/WB boundary.
module mem_stage #(
    parameter int PROC_BITS      = 32,
    parameter int PC_BITS        = 32,
    parameter int REG_ADDRS_BITS = 5,
    parameter int MEM_ADDR_BITS  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      flush,
    input  logic [PROC_BITS-1:0]      i_alu_result,
    input  logic [PROC_BITS-1:0]      i_rt_data,
    input  logic [REG_ADDRS_BITS-1:0] i_rd,
    input  logic                      i_RegWrite,
    input  logic                      i_MemRead,
    input  logic                      i_MemWrite,
    input  logic                      i_MemtoReg,
    input  logic [2:0]                i_ls_filter_op,
    input  logic                      i_pc_to_reg,
    input  logic [PC_BITS-1:0]        i_pc_return,
    input  logic [MEM_ADDR_BITS-1:0]  i_debug_addr,
    output logic [PROC_BITS-1:0]      o_debug_data,
    output logic [PROC_BITS-1:0]      o_mem_data,
    output logic [PROC_BITS-1:0]      o_alu_result,
    output logic [REG_ADDRS_BITS-1:0] o_rd,
    output logic                      o_RegWrite,
    output logic                      o_MemtoReg,
    output logic                      o_pc_to_reg,
    output logic [PC_BITS-1:0]        o_pc_return,
    output logic                      o_misaligned
);

    localparam int DEPTH = 2 ** MEM_ADDR_BITS;
    localparam int LANES = PROC_BITS / 8;

    logic [PROC_BITS-1:0] r_mem [DEPTH];

    logic [MEM_ADDR_BITS-1:0] w_idx;
    logic [1:0]               w_off;
    logic                     w_is_byte;
    logic                     w_is_half;
    logic                     w_is_word;
    logic                     w_signed;
    logic                     w_misaligned;
    logic                     w_do_store;
    logic [LANES-1:0]         w_be;
    logic [PROC_BITS-1:0]     w_wdata;
    logic [PROC_BITS-1:0]     w_word;
    logic [PROC_BITS-1:0]     w_shift;
    logic [PROC_BITS-1:0]     w_load;
    logic                     w_unused;

    assign w_idx    = i_alu_result[MEM_ADDR_BITS+1:2];
    assign w_off    = i_alu_result[1:0];
    assign w_unused = ^i_alu_result[PROC_BITS-1:MEM_ADDR_BITS+2];

    // Size decode: op[1:0]=00 byte, 01 half, anything else is a word.
    assign w_is_byte = (i_ls_filter_op[1:0] == 2'b00);
    assign w_is_half = (i_ls_filter_op[1:0] == 2'b01);
    assign w_is_word = i_ls_filter_op[1];
    assign w_signed  = ~i_ls_filter_op[2];

    assign w_misaligned = (i_MemRead | i_MemWrite) &
                          ((w_is_half & w_off[0]) |
                           (w_is_word & (w_off != 2'b00)));

    assign w_do_store = enable & ~flush & ~rst & i_MemWrite & ~w_misaligned;

    // Replicate store data across lanes and pick the lane enables.
    always_comb begin
        w_be    = '0;
        w_wdata = i_rt_data;
        if (w_is_byte) begin
            w_be    = LANES'(1) << w_off;
            w_wdata = {LANES{i_rt_data[7:0]}};
        end else if (w_is_half) begin
            w_be    = LANES'(3) << w_off;
            w_wdata = {(LANES/2){i_rt_data[15:0]}};
        end else begin
            w_be    = '1;
            w_wdata = i_rt_data;
        end
    end

    // Lane-masked write into data memory; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_do_store) begin
            for (int b = 0; b < LANES; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_off, 3'b000};

    // Lane select and extension of the loaded word.
    always_comb begin
        w_load = '0;
        if (i_MemRead & ~i_MemWrite & ~w_misaligned) begin
            if (w_is_byte) begin
                w_load = {{(PROC_BITS-8){w_signed & w_shift[7]}},
                          w_shift[7:0]};
            end else if (w_is_half) begin
                w_load = {{(PROC_BITS-16){w_signed & w_shift[15]}},
                          w_shift[15:0]};
            end else begin
                w_load = w_word;
            end
        end
    end

    assign o_debug_data = r_mem[i_debug_addr];

    // MEM/WB boundary registers: reset, then flush, then advance.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            o_mem_data   <= '0;
            o_alu_result <= '0;
            o_rd         <= '0;
            o_RegWrite   <= 1'b0;
            o_MemtoReg   <= 1'b0;
            o_pc_to_reg  <= 1'b0;
            o_pc_return  <= '0;
            o_misaligned <= 1'b0;
        end else if (enable) begin
            o_mem_data   <= w_load;
            o_alu_result <= i_alu_result;
            o_rd         <= i_rd;
            o_RegWrite   <= i_RegWrite;
            o_MemtoReg   <= i_MemtoReg;
            o_pc_to_reg  <= i_pc_to_reg;
            o_pc_return  <= i_pc_return;
            o_misaligned <= w_misaligned;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver queues expected MEM/WB contents,
// monitor pops one entry after each clock edge and compares.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        flush;
    logic [31:0] i_alu_result;
    logic [31:0] i_rt_data;
    logic [4:0]  i_rd;
    logic        i_RegWrite;
    logic        i_MemRead;
    logic        i_MemWrite;
    logic        i_MemtoReg;
    logic [2:0]  i_ls_filter_op;
    logic        i_pc_to_reg;
    logic [31:0] i_pc_return;
    logic [9:0]  i_debug_addr;
    logic [31:0] o_debug_data;
    logic [31:0] o_mem_data;
    logic [31:0] o_alu_result;
    logic [4:0]  o_rd;
    logic        o_RegWrite;
    logic        o_MemtoReg;
    logic        o_pc_to_reg;
    logic [31:0] o_pc_return;
    logic        o_misaligned;

    mem_stage dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .i_alu_result(i_alu_result), .i_rt_data(i_rt_data), .i_rd(i_rd),
        .i_RegWrite(i_RegWrite), .i_MemRead(i_MemRead),
        .i_MemWrite(i_MemWrite), .i_MemtoReg(i_MemtoReg),
        .i_ls_filter_op(i_ls_filter_op), .i_pc_to_reg(i_pc_to_reg),
        .i_pc_return(i_pc_return), .i_debug_addr(i_debug_addr),
        .o_debug_data(o_debug_data), .o_mem_data(o_mem_data),
        .o_alu_result(o_alu_result), .o_rd(o_rd),
        .o_RegWrite(o_RegWrite), .o_MemtoReg(o_MemtoReg),
        .o_pc_to_reg(o_pc_to_reg), .o_pc_return(o_pc_return),
        .o_misaligned(o_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        p2r;
        logic        mis;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   total = 0;
    int   bad   = 0;
    int   n     = 0;
    logic done  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each clock edge delivers one MEM/WB slot to compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mem_data", o_mem_data, e.mem);
                chk("alu_result", o_alu_result, e.alu);
                chk("misaligned", {31'd0, o_misaligned}, {31'd0, e.mis});
                chk("pc_return", o_pc_return, e.pc);
                chk("ctrl", {24'd0, o_rd, o_RegWrite, o_MemtoReg,
                             o_pc_to_reg},
                    {24'd0, e.rd, e.rw, e.m2r, e.p2r});
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic [31:0] rt,
                         input logic [2:0] op, input logic mr,
                         input logic mw, input logic en, input logic fl,
                         input logic rs, input logic [31:0] emem,
                         input logic emis);
        exp_t e;
        n++;
        rst            = rs;
        enable         = en;
        flush          = fl;
        i_alu_result   = addr;
        i_rt_data      = rt;
        i_ls_filter_op = op;
        i_MemRead      = mr;
        i_MemWrite     = mw;
        i_rd           = n[4:0];
        i_RegWrite     = n[1];
        i_MemtoReg     = mr;
        i_pc_to_reg    = n[0];
        i_pc_return    = 32'h1000 + n * 4;
        if (rs || fl) begin
            e = '{default: '0};
        end else if (!en) begin
            e = last;
        end else begin
            e.alu = addr;
            e.mem = emem;
            e.pc  = 32'h1000 + n * 4;
            e.rd  = n[4:0];
            e.rw  = n[1];
            e.m2r = mr;
            e.p2r = n[0];
            e.mis = emis;
        end
        last = e;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic dbg(input logic [9:0] idx, input logic [31:0] exp);
        i_debug_addr = idx;
        #1;
        chk("debug_word", o_debug_data, exp);
    endtask

    // Directed stimulus; issue(addr, rt, op, MR, MW, en, fl, rst, mem, mis)
    initial begin
        rst = 1'b1; enable = 1'b0; flush = 1'b0;
        i_alu_result = '0; i_rt_data = '0; i_rd = '0;
        i_RegWrite = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0;
        i_MemtoReg = 1'b0; i_ls_filter_op = 3'b011; i_pc_to_reg = 1'b0;
        i_pc_return = '0; i_debug_addr = '0;
        last = '{default: '0};

        issue(32'h0, 32'h0, 3'b011, 0, 0, 1, 0, 1, 32'h0, 0);
        issue(32'h0, 32'h0, 3'b011, 0, 0, 1, 0, 1, 32'h0, 0);

        issue(32'h10, 32'hDEADBEEF, 3'b011, 0, 1, 1, 0, 0, 32'h0, 0);
        dbg(10'd4, 32'hDEADBEEF);
        issue(32'h10, 32'h0, 3'b011, 1, 0, 1, 0, 0, 32'hDEADBEEF, 0);

        issue(32'h10, 32'h11223344, 3'b111, 0, 1, 1, 0, 0, 32'h0, 0);
        issue(32'h11, 32'h000000AA, 3'b000, 0, 1, 1, 0, 0, 32'h0, 0);
        dbg(10'd4, 32'h1122AA44);
        issue(32'h11, 32'h0, 3'b000, 1, 0, 1, 0, 0, 32'hFFFFFFAA, 0);
        issue(32'h11, 32'h0, 3'b100, 1, 0, 1, 0, 0, 32'h000000AA, 0);

        issue(32'h20, 32'h0, 3'b010, 0, 1, 1, 0, 0, 32'h0, 0);
        issue(32'h22, 32'h00008001, 3'b001, 0, 1, 1, 0, 0, 32'h0, 0);
        dbg(10'd8, 32'h80010000);
        issue(32'h22, 32'h0, 3'b001, 1, 0, 1, 0, 0, 32'hFFFF8001, 0);
        issue(32'h22, 32'h0, 3'b101, 1, 0, 1, 0, 0, 32'h00008001, 0);
        issue(32'h20, 32'h0, 3'b011, 1, 0, 1, 0, 0, 32'h80010000, 0);

        issue(32'h13, 32'h12345678, 3'b011, 0, 1, 1, 0, 0, 32'h0, 1);
        dbg(10'd4, 32'h1122AA44);
        issue(32'h21, 32'h0, 3'b001, 1, 0, 1, 0, 0, 32'h0, 1);
        issue(32'h11, 32'h0, 3'b101, 1, 0, 1, 0, 0, 32'h0, 1);

        issue(32'h10, 32'h0, 3'b011, 1, 0, 1, 0, 0, 32'h1122AA44, 0);
        issue(32'h10, 32'h55555555, 3'b011, 0, 1, 0, 0, 0, 32'h0, 0);
        issue(32'h10, 32'h55555555, 3'b011, 0, 1, 0, 0, 0, 32'h0, 0);
        dbg(10'd4, 32'h1122AA44);
        issue(32'h10, 32'h66666666, 3'b011, 0, 1, 1, 1, 0, 32'h0, 0);
        dbg(10'd4, 32'h1122AA44);
        issue(32'h12, 32'h0, 3'b000, 1, 0, 1, 0, 0, 32'h00000022, 0);

        issue(32'h30, 32'h0BADF00D, 3'b011, 0, 1, 1, 0, 0, 32'h0, 0);
        issue(32'h30, 32'h77777777, 3'b011, 0, 1, 1, 0, 1, 32'h0, 0);
        dbg(10'd12, 32'h0BADF00D);
        dbg(10'd4, 32'h1122AA44);
        issue(32'h1030, 32'h0, 3'b011, 1, 0, 1, 0, 0, 32'h0BADF00D, 0);

        issue(32'h30, 32'hCAFEF00D, 3'b011, 1, 1, 1, 0, 0, 32'h0, 0);
        issue(32'h30, 32'h0, 3'b011, 1, 0, 1, 0, 0, 32'hCAFEF00D, 0);
        issue(32'h33, 32'h0, 3'b000, 1, 0, 1, 0, 0, 32'hFFFFFFCA, 0);

        enable = 1'b0;
        i_MemRead = 1'b0;
        i_MemWrite = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: got timeout expected finish");
            $fatal(1, "watchdog");
        end
    end

endmodule
